fifo_parallel_to_serial: RTL and testbench
==========================================

// Module: fifo_parallel_to_serial
// PURPOSE
//  Transmit-side counterpart of the 8-lane serial-to-FIFO capture path. Reads
//  36-bit words from a standard FIFO (1-cycle read latency) and shifts each word
//  MSB-first onto 8 serial lanes, sd0..sd7, 4 bits per lane. A frame starts on a
//  start pulse and ends after the word with bit[35] (LAST) set. Used to drive
//  chip inputs and to loop back into the capture block for KC705 self-test.
// PARAMETERS
//  FIFO_WIDTH     36   FIFO word width; [35]=LAST, [34:32] ignored, [31:0] payload
//  BITS_PER_LANE  4    shift cycles per word (8 lanes x 4 = 32 payload bits)
//  TIMEOUT        255  max cycles waiting on fifo_empty before abort (8-bit counter)
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  rst            in   1   asynchronous, active-low reset
//  start          in   1   1-cycle pulse, begins a frame; ignored while busy
//  fifo_empty     in   1   FIFO empty flag
//  fifo_rd_en     out  1   FIFO read strobe, 1 cycle per word
//  fifo_dout      in   36  FIFO read data, valid the cycle after fifo_rd_en
//  sd0..sd7       out  1   serial lane outputs (registered)
//  sd_valid       out  1   high while lanes carry payload bits
//  busy           out  1   high from the cycle after start until frame done/abort
//  underflow_err  out  1   sticky abort flag; cleared by the next accepted start
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; sd0..sd7=0, sd_valid=0, busy=0,
//   fifo_rd_en=0, underflow_err=0; shift reg, bit and timeout counters = 0.
//  FSM: IDLE, FETCH, LATCH, SHIFT, DONE.
//  IDLE:  start=1 -> FETCH; clears underflow_err and the timeout counter.
//  FETCH: fifo_rd_en = (state==FETCH) & ~fifo_empty (combinational from state).
//   When fifo_empty=0 -> LATCH. When fifo_empty=1, increment the timeout counter.
//   When the counter reaches TIMEOUT -> IDLE and set underflow_err.
//  LATCH: capture fifo_dout into the shift reg; bit cnt=0 -> SHIFT.
//  SHIFT: for c=0..3, sdK = word[4K+3-c] and sd_valid=1.
//   Lane 0 carries bits [3:0]; lane 7 carries bits [31:28].
//   After c=3: if LAST=1 -> DONE, else -> FETCH (timeout counter cleared).
//  DONE:  one cycle; sd*=0, sd_valid=0 -> IDLE. busy drops on entry to IDLE.
//  Outside SHIFT, sd0..sd7=0 and sd_valid=0. A gap of at least 2 cycles
//   (FETCH, LATCH) separates consecutive words; this is accepted throughput.
//  Latency: start sampled at edge E0. fifo_rd_en is high in cycle 1 (FIFO
//   non-empty). First payload bit is on the lanes in cycle 3, last in cycle 6.
//  start while busy: ignored, with no effect on the frame.
//  fifo_empty is sampled only in FETCH, so no read is ever issued on empty.
//  Exactly one fifo_rd_en pulse per word.
//  Reset mid-frame: immediate return to IDLE; the partial word is discarded.
//   No further FIFO reads occur.
// TESTING
//  1 FIFO holds 36'h8_8765_4321, start pulse -> one rd_en. In cycles 3..6:
//    sd0 = 0,0,0,1 and sd7 = 1,0,0,0; sd_valid high for exactly 4 cycles;
//    busy drops in cycle 8.
//  2 FIFO holds 36'h0_FFFF_FFFF then 36'h8_0000_0000 -> 2 rd_en pulses.
//    All lanes are 1 for 4 cycles, then 0 for 4 valid cycles; >=2-cycle gap
//    between words; frame ends after the 2nd word.
//  3 FIFO empty at start, never filled -> no rd_en; after 255 FETCH cycles
//    busy=0 and underflow_err=1. Next start clears underflow_err.
//  4 FIFO empty for 10 cycles, then 36'h8_0000_00A5 written -> no timeout;
//    word sent with sd0 = 0,1,0,1 and sd1 = 1,0,1,0.
//  5 start re-pulsed during SHIFT -> no extra rd_en and no frame restart;
//    the output matches case 1 exactly.
//  6 rst asserted during SHIFT cycle c=1 -> all outputs 0 in the same cycle,
//    state IDLE; after release no rd_en until the next start.

Source files
------------

// File: rtl/fifo_parallel_to_serial.sv
// Reads 36-bit words from a 1-cycle-latency FIFO and shifts each payload MSB-first
// onto 8 serial lanes, 4 bits per lane; a frame ends after the word flagged LAST.
module fifo_parallel_to_serial #(
   parameter int FIFO_WIDTH    = 36,
   parameter int BITS_PER_LANE = 4,
   parameter int TIMEOUT       = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_dout,
   output logic                  sd0,
   output logic                  sd1,
   output logic                  sd2,
   output logic                  sd3,
   output logic                  sd4,
   output logic                  sd5,
   output logic                  sd6,
   output logic                  sd7,
   output logic                  sd_valid,
   output logic                  busy,
   output logic                  underflow_err
);

   localparam int LANES     = 8;
   localparam int PAYLOAD_W = LANES * BITS_PER_LANE;
   localparam int CNT_W     = (BITS_PER_LANE > 1) ? $clog2(BITS_PER_LANE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PER_LANE - 1);
   localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, SHIFT, DONE} state_t;

   state_t                 state, state_nxt;
   logic [PAYLOAD_W-1:0]   shreg;
   logic                   last_q;
   logic [CNT_W-1:0]       bit_cnt;
   logic [CNT_W-1:0]       cnt_inc;
   logic [7:0]             tmo_cnt;
   logic [LANES-1:0]       sd_q;
   logic                   sd_valid_q;
   logic                   err_q;
   logic                   unused_bits;

   // Bits [34:32] carry no meaning on the transmit side.
   assign unused_bits = ^fifo_dout[FIFO_WIDTH-2:PAYLOAD_W];

   // Lane k carries payload nibble k, MSB first: bit c of the lane is word[4k+3-c].
   function automatic logic [LANES-1:0] lane_slice(input logic [PAYLOAD_W-1:0] w,
                                                   input logic [CNT_W-1:0] c);
      logic [LANES-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++)
         r[k] = w[BITS_PER_LANE*k + BITS_PER_LANE - 1 - int'(c)];
      return r;
   endfunction

   assign cnt_inc = bit_cnt + 1'b1;

   always_comb begin
      state_nxt  = state;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_nxt  = LATCH;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt = IDLE;
            end
         end
         LATCH: state_nxt = SHIFT;
         SHIFT: if (bit_cnt == CNT_LAST) state_nxt = last_q ? DONE : FETCH;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         last_q     <= 1'b0;
         bit_cnt    <= '0;
         tmo_cnt    <= '0;
         sd_q       <= '0;
         sd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         sd_q       <= '0;
         sd_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  err_q   <= 1'b0;
                  tmo_cnt <= '0;
               end
            end
            FETCH: begin
               if (fifo_empty) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == TMO_LAST) err_q <= 1'b1;
               end
            end
            // Lanes are registered, so the first bit is loaded while latching the word.
            LATCH: begin
               shreg      <= fifo_dout[PAYLOAD_W-1:0];
               last_q     <= fifo_dout[FIFO_WIDTH-1];
               bit_cnt    <= '0;
               sd_q       <= lane_slice(fifo_dout[PAYLOAD_W-1:0], '0);
               sd_valid_q <= 1'b1;
            end
            SHIFT: begin
               bit_cnt <= cnt_inc;
               if (bit_cnt != CNT_LAST) begin
                  sd_q       <= lane_slice(shreg, cnt_inc);
                  sd_valid_q <= 1'b1;
               end else begin
                  tmo_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign {sd7, sd6, sd5, sd4, sd3, sd2, sd1, sd0} = sd_q;
   assign sd_valid      = sd_valid_q;
   assign busy          = (state != IDLE);
   assign underflow_err = err_q;

endmodule

// File: tb/tb_fifo_parallel_to_serial.sv
// Self-checking bench for fifo_parallel_to_serial: a queue-based FIFO model feeds the
// DUT and every cycle is compared against a frame timeline computed from word contents.
module tb_fifo_parallel_to_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [35:0] fifo_dout;
   logic        sd0, sd1, sd2, sd3, sd4, sd5, sd6, sd7;
   logic        sd_valid;
   logic        busy;
   logic        underflow_err;

   logic [35:0] fifo_q[$];
   logic [35:0] frame_w[$];
   logic        rd_q;
   int          vectors;
   int          errors;

   fifo_parallel_to_serial #(
      .FIFO_WIDTH(36), .BITS_PER_LANE(4), .TIMEOUT(255)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
      .sd0(sd0), .sd1(sd1), .sd2(sd2), .sd3(sd3),
      .sd4(sd4), .sd5(sd5), .sd6(sd6), .sd7(sd7),
      .sd_valid(sd_valid), .busy(busy), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] observe();
      return {fifo_rd_en, sd_valid, busy, underflow_err,
              sd7, sd6, sd5, sd4, sd3, sd2, sd1, sd0};
   endfunction

   // Expected {rd_en, sd_valid, busy, underflow_err, lanes} in cycle t after the start edge,
   // for n words whose first word becomes readable d cycles late. Each word takes 6 cycles:
   // read, latch, 4 shift cycles; the frame then spends one DONE cycle.
   function automatic logic [11:0] model(int t, int d, int n);
      logic       rd, vld, bsy;
      logic [7:0] lanes;
      int         rel, i, c;
      rd = 1'b0; vld = 1'b0; lanes = '0;
      bsy = (t >= 1) && (t <= 6*n + 1 + d);
      rel = t - 1 - d;
      if (t >= 1 && rel >= 0) begin
         i = rel / 6;
         c = (rel % 6) - 2;
         if (i < n) begin
            if (rel % 6 == 0) rd = 1'b1;
            if (c >= 0) begin
               vld = 1'b1;
               for (int k = 0; k < 8; k++) lanes[k] = frame_w[i][4*k + 3 - c];
            end
         end
      end
      return {rd, vld, bsy, 1'b0, lanes};
   endfunction

   // One clock: FIFO pops on the edge where rd_en was high; inputs change just after the edge;
   // outputs are sampled on the falling edge.
   task automatic step(input int t, input int push_t, input int restart_t);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rd_q && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      if (t == push_t) foreach (frame_w[j]) fifo_q.push_back(frame_w[j]);
      fifo_empty = (fifo_q.size() == 0);
      if (t == restart_t) start = 1'b1;
      @(negedge clk);
      rd_q = fifo_rd_en;
   endtask

   task automatic run_frame(input string name, input int d, input int restart_t);
      int          n;
      logic [11:0] obs, exp;
      n = frame_w.size();
      if (d == 0) begin
         foreach (frame_w[j]) fifo_q.push_back(frame_w[j]);
         fifo_empty = (fifo_q.size() == 0);
      end
      start = 1'b1;
      for (int t = 1; t <= 6*n + d + 4; t++) begin
         step(t, (d > 0) ? 1 + d : -1, restart_t);
         obs = observe();
         exp = model(t, d, n);
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got {rd,vld,busy,err,lanes}=%h, expected %h",
                     name, t, obs, exp);
         end
      end
      vectors++;
      if (fifo_q.size() != 0) begin
         errors++;
         $display("FAIL %s fifo_left: got %0d words unread, expected 0", name, fifo_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; rd_q = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (observe() !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: got %h, expected 000", observe());
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_word();
      frame_w = '{36'h8_8765_4321};
      run_frame("single_word", 0, -1);
   endtask

   task automatic test_two_words();
      frame_w = '{36'h0_FFFF_FFFF, 36'h8_0000_0000};
      run_frame("two_words", 0, -1);
   endtask

   task automatic test_timeout();
      int busy_cnt, rd_cnt;
      bit ended;
      frame_w.delete();
      fifo_empty = 1'b1;
      busy_cnt = 0; rd_cnt = 0; ended = 0;
      start = 1'b1;
      for (int t = 1; t <= 400; t++) begin
         step(t, -1, -1);
         if (fifo_rd_en) rd_cnt++;
         if (busy) busy_cnt++;
         else begin ended = 1; break; end
      end
      vectors++;
      if (!ended) begin
         errors++;
         $display("FAIL timeout_end: busy still high after 400 cycles, expected drop");
      end
      vectors++;
      if (busy_cnt != 255) begin
         errors++;
         $display("FAIL timeout_len: got %0d busy cycles, expected 255", busy_cnt);
      end
      vectors++;
      if (rd_cnt != 0) begin
         errors++;
         $display("FAIL timeout_rd: got %0d reads, expected 0", rd_cnt);
      end
      repeat (3) step(0, -1, -1);
      vectors++;
      if (underflow_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flag: got err=%b busy=%b, expected err=1 busy=0",
                  underflow_err, busy);
      end
   endtask

   task automatic test_err_clear();
      frame_w = '{36'h8_1234_5678};
      run_frame("err_clear", 0, -1);
   endtask

   task automatic test_late_data();
      frame_w = '{36'h8_0000_00A5};
      run_frame("late_data", 10, -1);
   endtask

   task automatic test_restart_ignored();
      frame_w = '{36'h8_8765_4321};
      run_frame("restart_ignored", 0, 4);
   endtask

   task automatic test_reset_mid();
      int bad;
      frame_w = '{36'h8_8765_4321};
      fifo_q.push_back(frame_w[0]);
      fifo_empty = 1'b0;
      start = 1'b1;
      for (int t = 1; t <= 3; t++) step(t, -1, -1);
      vectors++;
      if (sd_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre_shift: got sd_valid=%b, expected 1", sd_valid);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      vectors++;
      if (observe() !== 12'h000) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h, expected 000", observe());
      end
      @(negedge clk);
      rst = 1'b1;
      rd_q = 1'b0;
      fifo_q.push_back(36'h8_DEAD_BEEF);
      fifo_empty = 1'b0;
      bad = 0;
      for (int t = 1; t <= 10; t++) begin
         step(t, -1, -1);
         if (fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_after_release: got %0d cycles with rd_en/busy, expected 0", bad);
      end
      fifo_q.delete();
      fifo_empty = 1'b1;
      rd_q = 1'b0;
      step(0, -1, -1);
   endtask

   task automatic test_random();
      int n, d, rs;
      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(1, 3);
         d = $urandom_range(0, 12);
         rs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6*n + 1 + d) : -1;
         frame_w.delete();
         for (int i = 0; i < n; i++)
            frame_w.push_back({(i == n - 1), 3'($urandom), 32'($urandom)});
         run_frame("random", d, rs);
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_single_word();
      test_two_words();
      test_timeout();
      test_err_clear();
      test_late_data();
      test_restart_ignored();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
